serial_rx_8bit: RTL and testbench

- Serial-to-parallel receiver for the stream produced by the 8-bit function register when it shifts right: its LSB is emitted first on each shift.
- Samples one bit per `sin_valid` strobe and reassembles WIDTH bits into a word, LSB first.
- Presents each completed word through a one-entry valid/ready output buffer and reports overrun when a word completes while the buffer is still full.
- Sits between the shifting register's serial output and any parallel consumer.

---
 rtl/serial_rx_8bit.sv | 102 ++++++++++
 tb/tb_serial_rx_8bit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_8bit.sv
// Serial-to-parallel receiver: assembles WIDTH bits (LSB first) into a word and
// presents it through a one-entry valid/ready buffer with sticky overrun.
module serial_rx_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             sin_i,
  input  logic             sin_valid_i,
  input  logic             q_ready_i,
  output logic [WIDTH-1:0] q_o,
  output logic             q_valid_o,
  output logic [3:0]       bit_count_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  buf_state_e       buf_q, buf_d;
  // Only the upper WIDTH-1 bits of the shift register are ever read back: the
  // bit at position 0 is shifted out on every sample, so it is not stored.
  logic [WIDTH-2:0] sh_q, sh_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ov_q, ov_d;

  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             drain;

  assign shifted  = {sin_i, sh_q};
  assign complete = sin_valid_i && !clear_i && (cnt_q == LAST_BIT);
  assign drain    = (buf_q == BUF_FULL) && q_ready_i;

  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    ov_d  = ov_q;

    if (clear_i) begin
      sh_d  = '0;
      cnt_d = '0;
      ov_d  = 1'b0;
    end else if (sin_valid_i) begin
      sh_d  = shifted[WIDTH-1:1];
      cnt_d = (cnt_q == LAST_BIT) ? 4'd0 : cnt_q + 4'd1;
    end

    if (complete && (buf_q == BUF_FULL) && !q_ready_i) begin
      ov_d = 1'b1;
    end
  end

  // Output buffer: a completing word wins over a plain drain on the same edge.
  always_comb begin
    buf_d = buf_q;
    q_d   = q_q;

    if (drain) begin
      buf_d = BUF_EMPTY;
    end

    if (complete && ((buf_q == BUF_EMPTY) || q_ready_i)) begin
      q_d   = shifted;
      buf_d = BUF_FULL;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from the values present before the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= BUF_EMPTY;
      sh_q  <= '0;
      cnt_q <= '0;
      q_q   <= '0;
      ov_q  <= 1'b0;
    end else begin
      buf_q <= buf_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      q_q   <= q_d;
      ov_q  <= ov_d;
    end
  end

  assign q_o         = q_q;
  assign q_valid_o   = (buf_q == BUF_FULL);
  assign bit_count_o = cnt_q;
  assign busy_o      = (cnt_q != 4'd0);
  assign overrun_o   = ov_q;

endmodule

// File: tb/tb_serial_rx_8bit.sv
// Scoreboard bench for serial_rx_8bit: directed scenarios plus random traffic,
// checked against a bit-queue reference model of the receiver and buffer.
module tb_serial_rx_8bit;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         clear_i;
  logic         sin_i;
  logic         sin_valid_i;
  logic         q_ready_i;
  logic [W-1:0] q_o;
  logic         q_valid_o;
  logic [3:0]   bit_count_o;
  logic         busy_o;
  logic         overrun_o;

  serial_rx_8bit #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear_i),
    .sin_i       (sin_i),
    .sin_valid_i (sin_valid_i),
    .q_ready_i   (q_ready_i),
    .q_o         (q_o),
    .q_valid_o   (q_valid_o),
    .bit_count_o (bit_count_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // Reference model: received bits kept as a queue, word built arithmetically.
  bit           m_bits[$];
  logic [W-1:0] m_q;
  bit           m_full;
  bit           m_ov;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_q    = '0;
    m_full = 1'b0;
    m_ov   = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge(input bit v, input bit s, input bit r, input bit c);
    bit           was_full;
    logic [W-1:0] word;
    was_full = m_full;
    if (was_full && r) m_full = 1'b0;
    if (c) begin
      m_bits.delete();
      m_ov = 1'b0;
    end else if (v) begin
      m_bits.push_back(s);
      if (m_bits.size() == W) begin
        word = '0;
        for (int i = 0; i < W; i++) word = word + (W'(m_bits[i]) << i);
        m_bits.delete();
        if (!was_full || r) begin
          m_q    = word;
          m_full = 1'b1;
          exp_q.push_back(word);
        end else begin
          m_ov = 1'b1;
        end
      end
    end
  endtask

  // Inputs change 1 time unit after the falling edge; one rising edge per call.
  task automatic drive(input bit v, input bit s, input bit r, input bit c);
    sin_valid_i = v;
    sin_i       = s;
    q_ready_i   = r;
    clear_i     = c;
    @(posedge clk);
    model_edge(v, s, r, c);
    @(negedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit r);
    logic [W-1:0] tmp;
    tmp = w;
    for (int i = 0; i < W; i++) drive(1'b1, tmp[i], r, 1'b0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_async_q", 32'(q_o), 32'h0);
    check("rst_async_q_valid", 32'(q_valid_o), 32'h0);
    check("rst_async_bit_count", 32'(bit_count_o), 32'h0);
    check("rst_async_overrun", 32'(overrun_o), 32'h0);
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: status compared every cycle; words popped on each handshake.
  always @(negedge clk) begin
    #3;
    if (mon_en) begin
      check("mon_q_valid", 32'(q_valid_o), 32'(m_full));
      check("mon_bit_count", 32'(bit_count_o), 32'(m_bits.size()));
      check("mon_busy", 32'(busy_o), 32'(m_bits.size() != 0));
      check("mon_overrun", 32'(overrun_o), 32'(m_ov));
      if (q_valid_o && q_ready_i) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", 32'(q_o), 32'hFFFF_FFFF);
        end else begin
          check("sb_word", 32'(q_o), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    clear_i     = 1'b0;
    sin_i       = 1'b0;
    sin_valid_i = 1'b0;
    q_ready_i   = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check("reset_q", 32'(q_o), 32'h0);
    check("reset_q_valid", 32'(q_valid_o), 32'h0);
    check("reset_busy", 32'(busy_o), 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Async reset mid-word with the buffer full, then a fresh word.
    send_word(8'h5A, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_reset_busy", 32'(busy_o), 32'h1);
    pulse_reset();
    send_word(8'h3C, 1'b0);
    check("after_reset_q", 32'(q_o), 32'h3C);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Basic receive with a stalled consumer.
    send_word(8'hAA, 1'b0);
    check("basic_q", 32'(q_o), 32'hAA);
    check("basic_q_valid", 32'(q_valid_o), 32'h1);
    check("basic_bit_count", 32'(bit_count_o), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("basic_hold", 32'(q_valid_o), 32'h1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("basic_drained", 32'(q_valid_o), 32'h0);

    // Overrun: second word dropped while the buffer is full.
    send_word(8'hAA, 1'b0);
    send_word(8'h55, 1'b0);
    check("ovr_q", 32'(q_o), 32'hAA);
    check("ovr_flag", 32'(overrun_o), 32'h1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_drained", 32'(q_valid_o), 32'h0);
    check("ovr_sticky", 32'(overrun_o), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_cleared", 32'(overrun_o), 32'h0);

    // Streaming with ready held high: one-cycle valid pulses, no loss.
    send_word(8'h0F, 1'b1);
    check("stream_q0", 32'(q_o), 32'h0F);
    check("stream_v0", 32'(q_valid_o), 32'h1);
    send_word(8'hF0, 1'b1);
    check("stream_q1", 32'(q_o), 32'hF0);
    check("stream_v1", 32'(q_valid_o), 32'h1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("stream_pulse_end", 32'(q_valid_o), 32'h0);
    check("stream_overrun", 32'(overrun_o), 32'h0);

    // Drain and completion on the same edge.
    send_word(8'h11, 1'b0);
    for (int i = 0; i < W - 1; i++) drive(1'b1, 1'(8'hEE >> i), 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("simul_q", 32'(q_o), 32'hEE);
    check("simul_q_valid", 32'(q_valid_o), 32'h1);
    check("simul_overrun", 32'(overrun_o), 32'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Clear beats a simultaneous valid bit, then a gapped word.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    check("clear_bit_count", 32'(bit_count_o), 32'h0);
    check("clear_overrun", 32'(overrun_o), 32'h0);
    for (int i = 0; i < W; i++) begin
      drive(1'b1, 1'(8'h81 >> i), 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("gap_q", 32'(q_o), 32'h81);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic against the reference model.
    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
            $urandom_range(0, 40) == 0);
    end

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
